// File: rtl/uart_stim_driver.sv
// UART stimulus driver: a FIFO of queued bytes is serialised onto a registered tx line.
// The frame format, the bit period and an optional sticky run watchdog are set by parameters.
module uart_stim_driver #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter bit IDLE_LEVEL      = 1'b1,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic                       EXCLK,
  input  logic                       btnC,
  input  logic                       tx_en,
  input  logic                       wr_en,
  input  logic [DATA_BITS-1:0]       wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [FIFO_DEPTH_LOG2:0]   count,
  output logic                       overflow,
  output logic                       tx,
  output logic                       busy,
  output logic                       timeout
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int CNW   = FIFO_DEPTH_LOG2 + 1;
  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        wptr, rptr;
  logic [CW-1:0]        baud;
  logic [2:0]           bitn;
  logic [DATA_BITS-1:0] sh, dat;
  state_t               state, state_nxt;
  logic                 push, pop, bit_end, last_bit, tx_nxt;

  assign full    = (count == CNW'(DEPTH));
  assign empty   = (count == '0);
  // A push against a full FIFO is dropped, even if a pop happens on the same edge.
  assign push    = wr_en && !full;
  assign bit_end = (baud == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_nxt = state;
    last_bit  = 1'b0;
    case (state)
      S_IDLE:  if (tx_en && !empty) state_nxt = S_START;
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA: begin
        last_bit = (bitn == 3'(DATA_BITS - 1));
        if (bit_end && last_bit) state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR:   if (bit_end) state_nxt = S_STOP;
      S_STOP: begin
        last_bit = (bitn == 3'(STOP_BITS - 1));
        if (bit_end && last_bit) state_nxt = (tx_en && !empty) ? S_START : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // tx only moves on a bit boundary or when a frame is launched from idle.
  always_comb begin
    busy   = (state != S_IDLE);
    pop    = (state_nxt == S_START) && (state != S_START);
    tx_nxt = tx;
    if (state == S_IDLE || bit_end) begin
      case (state_nxt)
        S_START: tx_nxt = ~IDLE_LEVEL;
        S_DATA:  tx_nxt = (state == S_START) ? sh[0] : sh[1];
        S_PAR:   tx_nxt = (PARITY == 1) ? ~^dat : ^dat;
        default: tx_nxt = IDLE_LEVEL;
      endcase
    end
  end

  always_ff @(posedge EXCLK) begin
    if (btnC) begin
      state    <= S_IDLE;
      tx       <= IDLE_LEVEL;
      baud     <= '0;
      bitn     <= '0;
      sh       <= '0;
      dat      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      tx    <= tx_nxt;
      if (state == S_IDLE || bit_end) baud <= '0;
      else                            baud <= baud + CW'(1);
      if (state_nxt != state) bitn <= '0;
      else if (bit_end)       bitn <= bitn + 3'd1;
      if (pop) begin
        sh   <= mem[rptr];
        dat  <= mem[rptr];
        rptr <= rptr + PW'(1);
      end else if (state == S_DATA && bit_end) begin
        sh <= sh >> 1;
      end
      if (push) wptr <= wptr + PW'(1);
      if (wr_en && full) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNW'(1);
        2'b01:   count <= count - CNW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge EXCLK) begin
    if (push && !btnC) mem[wptr] <= wr_data;
  end

  if (TIMEOUT_CYCLES != 0) begin : g_wd
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd;
    always_ff @(posedge EXCLK) begin
      if (btnC) begin
        wd      <= '0;
        timeout <= 1'b0;
      end else begin
        if (wd != WW'(TIMEOUT_CYCLES)) wd <= wd + WW'(1);
        if (wd == WW'(TIMEOUT_CYCLES - 1)) timeout <= 1'b1;
      end
    end
  end else begin : g_nowd
    assign timeout = 1'b0;
  end
endmodule

// File: tb/tb_uart_stim_driver.sv
// Bench for uart_stim_driver: four instances (8N1 with watchdog, 8E1, 8O1, 8E2), all at 4 clocks per bit.
// Vectors hold hand-built frames; multi-cycle corners are written out as explicit sequences.
module tb_uart_stim_driver;
  logic       EXCLK = 1'b0;
  logic       btnC = 1'b1, tx_en = 1'b0, wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic [3:0] tx_v, busy_v, full_v, empty_v, ovf_v, to_v;
  logic [4:0] cnt_a [4];
  int         total = 0, bad = 0;

  always #5 EXCLK = ~EXCLK;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_stim_driver #(
      .CLKS_PER_BIT(4), .DATA_BITS(8),
      .PARITY(g == 0 ? 0 : (g == 2 ? 1 : 2)),
      .STOP_BITS(g == 3 ? 2 : 1), .FIFO_DEPTH_LOG2(4), .IDLE_LEVEL(1'b1),
      .TIMEOUT_CYCLES(g == 0 ? 2000 : 0)
    ) u_dut (
      .EXCLK(EXCLK), .btnC(btnC), .tx_en(tx_en), .wr_en(wr_en), .wr_data(wr_data),
      .full(full_v[g]), .empty(empty_v[g]), .count(cnt_a[g]), .overflow(ovf_v[g]),
      .tx(tx_v[g]), .busy(busy_v[g]), .timeout(to_v[g])
    );
  end

  typedef struct {
    int          d;
    logic [7:0]  b;
    int          n;
    logic [11:0] f;   // frame bits, index 0 sent first
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge EXCLK);
    #1;
  endtask

  task automatic do_reset();
    btnC = 1'b1; wr_en = 1'b0; tx_en = 1'b0;
    tick(); tick();
    btnC = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t        vt [8];
    logic [11:0] bb [3];
    logic [7:0]  rx, exp_b;

    vt[0] = '{d:0, b:8'hA5, n:10, f:{2'b00, 1'b1, 8'hA5, 1'b0}};
    vt[1] = '{d:1, b:8'hA5, n:11, f:{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}};
    vt[2] = '{d:2, b:8'hA5, n:11, f:{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}};
    vt[3] = '{d:0, b:8'h01, n:10, f:{2'b00, 1'b1, 8'h01, 1'b0}};
    vt[4] = '{d:1, b:8'h07, n:11, f:{1'b0, 1'b1, 1'b1, 8'h07, 1'b0}};
    vt[5] = '{d:2, b:8'h00, n:11, f:{1'b0, 1'b1, 1'b1, 8'h00, 1'b0}};
    vt[6] = '{d:1, b:8'hFF, n:11, f:{1'b0, 1'b1, 1'b0, 8'hFF, 1'b0}};
    vt[7] = '{d:2, b:8'h80, n:11, f:{1'b0, 1'b1, 1'b0, 8'h80, 1'b0}};
    bb[0] = {2'b11, 1'b0, 8'h00, 1'b0};
    bb[1] = {2'b11, 1'b0, 8'hFF, 1'b0};
    bb[2] = {2'b11, 1'b0, 8'h3C, 1'b0};

    // Reset values, then a quiet line
    do_reset();
    chk("rst_tx", tx_v[0], 1);       chk("rst_busy", busy_v[0], 0);
    chk("rst_full", full_v[0], 0);   chk("rst_empty", empty_v[0], 1);
    chk("rst_count", cnt_a[0], 0);   chk("rst_ovf", ovf_v[0], 0);
    chk("rst_timeout", to_v[0], 0);  chk("rst_tx_8e2", tx_v[3], 1);
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("idle_line", {tx_v[0], busy_v[0], empty_v[0], cnt_a[0]}, {1'b1, 1'b0, 1'b1, 5'd0});
    end

    // Single frames, one per vector
    for (int i = 0; i < 8; i++) begin
      do_reset();
      tx_en = 1'b1; wr_en = 1'b1; wr_data = vt[i].b;
      tick();
      wr_en = 1'b0;
      chk("latency_tx_idle", tx_v[vt[i].d], 1);
      chk("latency_count", cnt_a[vt[i].d], 1);
      tick();
      for (int k = 0; k < vt[i].n * 4; k++) begin
        chk($sformatf("vec%0d_bit%0d", i, k / 4), tx_v[vt[i].d], vt[i].f[k / 4]);
        tick();
      end
      chk($sformatf("vec%0d_busy_end", i), busy_v[vt[i].d], 0);
      chk($sformatf("vec%0d_empty_end", i), empty_v[vt[i].d], 1);
      chk($sformatf("vec%0d_tx_end", i), tx_v[vt[i].d], 1);
    end

    // Back-to-back 8E2 frames with no idle gap
    do_reset();
    wr_en = 1'b1;
    wr_data = 8'h00; tick();
    wr_data = 8'hFF; tick();
    wr_data = 8'h3C; tick();
    wr_en = 1'b0;
    chk("b2b_count3", cnt_a[3], 3);
    tx_en = 1'b1;
    tick();
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < 48; k++) begin
        if (k == 0) chk($sformatf("b2b_count_f%0d", j), cnt_a[3], 5'(2 - j));
        chk($sformatf("b2b_f%0d_bit%0d", j, k / 4), tx_v[3], bb[j][k / 4]);
        tick();
      end
    chk("b2b_busy_end", busy_v[3], 0);
    chk("b2b_empty_end", empty_v[3], 1);

    // tx_en dropped mid-frame: frame finishes, next waits for re-enable
    do_reset();
    tx_en = 1'b1; wr_en = 1'b1; wr_data = 8'h11;
    tick();
    wr_data = 8'h22;
    tick();
    wr_en = 1'b0;
    chk("hold_count_pushpop", cnt_a[0], 1);
    chk("hold_busy_start", busy_v[0], 1);
    for (int k = 0; k < 39; k++) begin
      if (k == 10) tx_en = 1'b0;
      tick();
    end
    chk("hold_busy_last_cycle", busy_v[0], 1);
    tick();
    chk("hold_busy_after", busy_v[0], 0);
    chk("hold_count_after", cnt_a[0], 1);
    chk("hold_tx_after", tx_v[0], 1);
    repeat (20) tick();
    chk("hold_stays_idle", {busy_v[0], cnt_a[0]}, {1'b0, 5'd1});
    tx_en = 1'b1;
    tick();
    chk("resume_busy", busy_v[0], 1);
    chk("resume_tx", tx_v[0], 0);
    chk("resume_count", cnt_a[0], 0);

    // Overflow, then drain with refills across the pointer wrap
    do_reset();
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        chk("ovf_full_before", full_v[0], 1);
        chk("ovf_clear_before", ovf_v[0], 0);
      end
      wr_en = 1'b1; wr_data = 8'(16 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("ovf_full", full_v[0], 1);
    chk("ovf_count", cnt_a[0], 16);
    chk("ovf_flag", ovf_v[0], 1);
    tx_en = 1'b1;
    tick();
    for (int j = 0; j < 32; j++) begin
      rx = '0;
      for (int k = 0; k < 40; k++) begin
        if (k == 0) chk($sformatf("wrap_count_f%0d", j), cnt_a[0], (j <= 16) ? 5'd15 : 5'(31 - j));
        if (k == 2) begin
          chk($sformatf("wrap_start_f%0d", j), tx_v[0], 0);
          if (j < 16) begin wr_en = 1'b1; wr_data = 8'(128 + j); end
        end
        if (k == 3) wr_en = 1'b0;
        if (k >= 6 && k <= 34 && ((k - 2) % 4) == 0) rx[(k - 6) / 4] = tx_v[0];
        if (k == 38) chk($sformatf("wrap_stop_f%0d", j), tx_v[0], 1);
        tick();
      end
      exp_b = (j < 16) ? 8'(16 + j) : 8'(128 + j - 16);
      chk($sformatf("wrap_byte_f%0d", j), rx, exp_b);
    end
    chk("wrap_busy_end", busy_v[0], 0);
    chk("wrap_empty_end", empty_v[0], 1);
    chk("wrap_ovf_sticky", ovf_v[0], 1);

    // Reset during DATA, then watchdog timing from that reset's release
    tx_en = 1'b1; wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    tick();
    repeat (10) tick();
    chk("mid_busy", busy_v[0], 1);
    btnC = 1'b1;
    tick();
    chk("mid_rst_tx", tx_v[0], 1);
    chk("mid_rst_empty", empty_v[0], 1);
    chk("mid_rst_busy", busy_v[0], 0);
    chk("mid_rst_count", cnt_a[0], 0);
    chk("mid_rst_ovf", ovf_v[0], 0);
    btnC = 1'b0;
    for (int c = 1; c < 2000; c++) tick();
    chk("wd_low_at_1999", to_v[0], 0);
    tick();
    chk("wd_high_at_2000", to_v[0], 1);
    repeat (100) tick();
    chk("wd_sticky", to_v[0], 1);
    chk("wd_disabled", to_v[1], 0);
    chk("wd_no_tx_effect", {busy_v[0], tx_v[0]}, {1'b0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
